// File: rtl/multiword_add_seq_if.sv
// Operand/result handshake bundle for multiword_add_seq.
// The master drives operands and consumes results; the slave is the sequencer.
interface multiword_add_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = WIDTH * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/multiword_add_seq.sv
// Wide add/subtract built from one WIDTH-bit slice, iterated LS word first
// with the carry held in a register between slices.
module multiword_add_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    multiword_add_seq_if.slave        bus
);
    localparam int unsigned W     = WIDTH * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    int unsigned        base;
    logic [WIDTH:0]     slice;
    logic               last_word;

    // Shared slice: current word of A plus current word of B' plus carry
    always_comb begin
        base      = 32'(idx_q) * WIDTH;
        slice     = (WIDTH+1)'(a_q[base +: WIDTH])
                  + (WIDTH+1)'(b_q[base +: WIDTH])
                  + (WIDTH+1)'(carry_q);
        last_word = (idx_q == IDX_W'(WORDS - 1));
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
                    carry_d = bus.in_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: WIDTH] = slice[WIDTH-1:0];
                carry_d              = slice[WIDTH];
                if (last_word) begin
                    cout_d  = slice[WIDTH];
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice[WIDTH-1] != a_q[W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered copies of the next state
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
endmodule
